// File: rtl/mips_mult_div_if.sv
// mips_mult_div_if: connects the issuing control logic to the multiply/divide unit.
//   start       issue strobe; sampled only while busy=0
//   op          operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a   rs value (multiplicand / dividend)
//   operand_b   rt value (multiplier / divisor)
//   hi_we       MTHI strobe; loads write_data into hi
//   lo_we       MTLO strobe; loads write_data into lo
//   write_data  data for MTHI/MTLO
//   hi, lo      HI/LO registers, readable any cycle (MFHI/MFLO)
//   busy        an operation is in flight
//   done        one-cycle pulse when an operation has just written hi/lo
//   div_by_zero qualifies done; set for DIV/DIVU with a zero divisor
interface mips_mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, hi_we, lo_we, write_data,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_we, lo_we, write_data,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mips_mult_div.sv
// mips_mult_div: iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO pair,
// plus MTHI/MTLO writes. One iteration per cycle for WIDTH cycles, then a
// sign-adjust cycle that writes hi/lo and pulses done.
//   clk   rising-edge clock
//   rst   synchronous active-high reset; aborts any in-flight op
//   bus   mips_mult_div_if.slave (operands, op, MTHI/MTLO, hi/lo, status)
//
// state   | meaning
// S_IDLE  | waiting for start; MTHI/MTLO honoured here
// S_CALC  | one shift-add / shift-subtract iteration per cycle
// S_ADJUST| sign correction, write hi/lo, pulse done
module mips_mult_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  mips_mult_div_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ADJUST} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi;   // product upper half / partial remainder
  logic [WIDTH-1:0]   acc_lo;   // multiplier being shifted out / quotient shifting in
  logic [WIDTH-1:0]   mag_b;    // multiplicand / divisor magnitude
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               dz;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               done_r, dz_r;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Signed ops (op[0]=0) work on magnitudes; signs are reapplied in S_ADJUST.
  assign a_neg    = ~bus.op[0] & bus.operand_a[WIDTH-1];
  assign b_neg    = ~bus.op[0] & bus.operand_b[WIDTH-1];
  assign mag_a_in = a_neg ? -bus.operand_a : bus.operand_a;
  assign mag_b_in = b_neg ? -bus.operand_b : bus.operand_b;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};
  assign div_ok    = ~div_diff[WIDTH];

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -acc_lo : acc_lo;
  // With a zero divisor the remainder path ends holding |a|; negating it for
  // a negative dividend restores the original operand_a.
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_CALC;
      S_CALC:   if (cnt == CNT_W'(WIDTH-1)) state_nxt = S_ADJUST;
      S_ADJUST: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mag_b   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= mag_a_in;
            mag_b   <= mag_b_in;
            is_div  <= bus.op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dz      <= bus.op[1] & (bus.operand_b == '0);
          end else begin
            if (bus.hi_we) hi_r <= bus.write_data;
            if (bus.lo_we) lo_r <= bus.write_data;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_ADJUST: begin
          if (is_div) begin
            hi_r <= rem_fix;
            lo_r <= dz ? '1 : quo_fix;
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
          done_r <= 1'b1;
          dz_r   <= dz;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dz_r;

endmodule
